// File: rtl/bt_pkg.sv
// Shared encodings and constants for the master-side page procedure.
// Imported by page_train_ctrl and page_slot_cnt.
package bt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PAGE = 2'd1,
        ST_MPR  = 2'd2
    } page_state_e;

    localparam int unsigned TRAIN_SLOTS  = 16;
    localparam int unsigned PRESP_TO     = 8;
    localparam int unsigned K_NUDGE_STEP = 2;

    localparam int unsigned REP_W   = 9;
    localparam int unsigned KN_W    = 5;
    localparam int unsigned ABCNT_W = 4;
    localparam int unsigned TO_W    = 16;

endpackage

// File: rtl/page_slot_cnt.sv
// Train bookkeeping: slot within train, train repetitions, A/B half and k_nudge.
// Advances on tick unless held; clr restarts everything for a fresh page.
module page_slot_cnt #(
    parameter int unsigned TRAIN_SLOTS = bt_pkg::TRAIN_SLOTS
) (
    input  logic       clk_6M,
    input  logic       rstz,
    input  logic       clr_i,
    input  logic       init_atrain_i,
    input  logic       tick_i,
    input  logic       hold_i,
    input  logic [8:0] npage_i,
    output logic       atrain_o,
    output logic [4:0] k_nudge_o,
    output logic [3:0] ab_count_o
);
    import bt_pkg::*;

    localparam int unsigned SLOT_W = (TRAIN_SLOTS > 1) ? $clog2(TRAIN_SLOTS) : 1;

    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic               half_q, half_d;
    logic               atrain_q, atrain_d;
    logic [KN_W-1:0]    k_q, k_d;
    logic [ABCNT_W-1:0] ab_q, ab_d;
    logic [REP_W-1:0]   npage_eff;
    logic               train_end;
    logic               rep_end;

    // Next-state: train end closes a repetition; a full set of Npage trains flips A/B.
    always_comb begin
        slot_d    = slot_q;
        rep_d     = rep_q;
        half_d    = half_q;
        atrain_d  = atrain_q;
        k_d       = k_q;
        ab_d      = ab_q;
        npage_eff = (npage_i == '0) ? REP_W'(1) : npage_i;
        train_end = (slot_q == SLOT_W'(TRAIN_SLOTS - 1));
        rep_end   = (rep_q == npage_eff - REP_W'(1));

        if (clr_i) begin
            slot_d   = '0;
            rep_d    = '0;
            half_d   = 1'b0;
            atrain_d = init_atrain_i;
            k_d      = '0;
            ab_d     = '0;
        end else if (tick_i && !hold_i) begin
            slot_d = train_end ? '0 : slot_q + SLOT_W'(1);
            if (train_end) begin
                if (rep_end) begin
                    rep_d    = '0;
                    atrain_d = ~atrain_q;
                    half_d   = ~half_q;
                    if (half_q) begin
                        k_d = k_q + KN_W'(K_NUDGE_STEP);
                        if (ab_q != '1) begin
                            ab_d = ab_q + ABCNT_W'(1);
                        end
                    end
                end else begin
                    rep_d = rep_q + REP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            slot_q   <= '0;
            rep_q    <= '0;
            half_q   <= 1'b0;
            atrain_q <= 1'b0;
            k_q      <= '0;
            ab_q     <= '0;
        end else begin
            slot_q   <= slot_d;
            rep_q    <= rep_d;
            half_q   <= half_d;
            atrain_q <= atrain_d;
            k_q      <= k_d;
            ab_q     <= ab_d;
        end
    end

    assign atrain_o   = atrain_q;
    assign k_nudge_o  = k_q;
    assign ab_count_o = ab_q;

endmodule

// File: rtl/page_train_ctrl.sv
// Master page sequencer: IDLE/PAGE/MPR state, page timeout, response timeout,
// clock-freeze request and success/timeout pulses. Train counters live in page_slot_cnt.
module page_train_ctrl #(
    parameter int unsigned TRAIN_SLOTS = bt_pkg::TRAIN_SLOTS,
    parameter int unsigned PRESP_TO    = bt_pkg::PRESP_TO
) (
    input  logic        clk_6M,
    input  logic        rstz,
    input  logic        m_tslot_p,
    input  logic        page_start_p,
    input  logic        page_abort_p,
    input  logic        rx_id_p,
    input  logic        mpr_done_p,
    input  logic        mpr_fail_p,
    input  logic [8:0]  regi_Npage,
    input  logic        regi_init_Atrain,
    input  logic [15:0] regi_pageTO,
    output logic        page,
    output logic        mpr,
    output logic        Atrain,
    output logic [4:0]  k_nudge,
    output logic [3:0]  pageAB_2Npage_count,
    output logic        prm_clock_frozen,
    output logic        page_succ_p,
    output logic        page_timeout_p
);
    import bt_pkg::*;

    localparam int unsigned PRESP_W = $clog2(PRESP_TO + 1);

    page_state_e        state_q, state_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [PRESP_W-1:0] presp_q, presp_d;
    logic               page_q, mpr_q, succ_q, succ_d, tout_q, tout_d;
    logic               slot_clr, slot_hold, to_hit;

    // Next state; branch order encodes abort > timeout > done > rx/fail/presp > slot advance.
    always_comb begin
        state_d   = state_q;
        to_cnt_d  = to_cnt_q;
        presp_d   = presp_q;
        succ_d    = 1'b0;
        tout_d    = 1'b0;
        slot_clr  = 1'b0;
        slot_hold = 1'b1;
        to_hit    = m_tslot_p && (regi_pageTO != '0) &&
                    (to_cnt_q == regi_pageTO - TO_W'(1));

        if (page_abort_p) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (page_start_p) begin
                        state_d  = ST_PAGE;
                        to_cnt_d = '0;
                        slot_clr = 1'b1;
                    end
                end
                ST_PAGE: begin
                    if (m_tslot_p) to_cnt_d = to_cnt_q + TO_W'(1);
                    if (to_hit) begin
                        state_d = ST_IDLE;
                        tout_d  = 1'b1;
                    end else if (rx_id_p) begin
                        state_d = ST_MPR;
                        presp_d = '0;
                    end else begin
                        slot_hold = 1'b0;
                    end
                end
                ST_MPR: begin
                    if (m_tslot_p) to_cnt_d = to_cnt_q + TO_W'(1);
                    if (to_hit) begin
                        state_d = ST_IDLE;
                        tout_d  = 1'b1;
                    end else if (mpr_done_p) begin
                        state_d = ST_IDLE;
                        succ_d  = 1'b1;
                    end else if (mpr_fail_p ||
                                 (m_tslot_p && presp_q == PRESP_W'(PRESP_TO - 1))) begin
                        state_d = ST_PAGE;
                    end else if (m_tslot_p) begin
                        presp_d = presp_q + PRESP_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state_q  <= ST_IDLE;
            to_cnt_q <= '0;
            presp_q  <= '0;
            page_q   <= 1'b0;
            mpr_q    <= 1'b0;
            succ_q   <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            presp_q  <= presp_d;
            page_q   <= (state_d == ST_PAGE);
            mpr_q    <= (state_d == ST_MPR);
            succ_q   <= succ_d;
            tout_q   <= tout_d;
        end
    end

    page_slot_cnt #(
        .TRAIN_SLOTS (TRAIN_SLOTS)
    ) u_slot_cnt (
        .clk_6M        (clk_6M),
        .rstz          (rstz),
        .clr_i         (slot_clr),
        .init_atrain_i (regi_init_Atrain),
        .tick_i        (m_tslot_p),
        .hold_i        (slot_hold),
        .npage_i       (regi_Npage),
        .atrain_o      (Atrain),
        .k_nudge_o     (k_nudge),
        .ab_count_o    (pageAB_2Npage_count)
    );

    assign page             = page_q;
    assign mpr              = mpr_q;
    assign prm_clock_frozen = mpr_q;
    assign page_succ_p      = succ_q;
    assign page_timeout_p   = tout_q;

endmodule

// File: doc/page_train_ctrl.md
# page_train_ctrl

Sequencer for the master-side page procedure that drives the hop-selection control-word block. It owns the page state (page / master page response), the A/B train selection, the k_nudge progression, the 2·Npage repetition count and the clock-freeze request used when an ID response is caught. It sits between the link controller registers/LC state machine and the hop control-word logic, and runs on the 6 MHz baseband clock, advancing on master TX-slot strobes.

## Interface
Parameters:
- TRAIN_SLOTS, 16: slots per train (16 frequencies, 2 IDs per TX slot).
- PRESP_TO, 8: master page-response timeout in slots.

Ports:
- clk_6M  in  1  baseband clock.
- rstz  in  1  asynchronous, active-low reset.
- m_tslot_p  in  1  one-cycle pulse at each master slot boundary (625 µs).
- page_start_p  in  1  start paging.
- page_abort_p  in  1  abort any activity; return to IDLE.
- rx_id_p  in  1  slave ID received in a page RX slot.
- mpr_done_p  in  1  FHS acknowledged; page succeeded.
- mpr_fail_p  in  1  master page response failed.
- regi_Npage  in  9  train repetitions, 1..256 (0 treated as 1).
- regi_init_Atrain  in  1  1 = start with train A.
- regi_pageTO  in  16  page timeout in slots; 0 = no timeout.
- page  out  1  page substate active.
- mpr  out  1  master page response substate active.
- Atrain  out  1  current train (1 = A).
- k_nudge  out  5  nudge value, step 2, mod 32.
- pageAB_2Npage_count  out  4  completed A+B rounds, saturates at 15.
- prm_clock_frozen  out  1  freeze CLKE/k_offset/k_nudge in the hop block.
- page_succ_p  out  1  one-cycle success pulse.
- page_timeout_p  out  1  one-cycle timeout pulse.

## Operation
- States: IDLE, PAGE, MPR. page = (state==PAGE), mpr = (state==MPR); prm_clock_frozen = (state==MPR).
- IDLE: page_start_p → PAGE; slot_cnt, rep_cnt, half, k_nudge, pageAB_2Npage_count, to_cnt cleared; Atrain ← regi_init_Atrain.
- PAGE, on each m_tslot_p: slot_cnt++ (4 bits). At slot_cnt==TRAIN_SLOTS-1 (train end): if rep_cnt==max(regi_Npage,1)-1, then rep_cnt←0, Atrain toggles, half toggles; when half was 1 (A+B pair complete), k_nudge←k_nudge+2 mod 32, pageAB_2Npage_count++ saturating at 15. Otherwise rep_cnt++.
- Timeout: to_cnt (16 bits) increments on m_tslot_p in PAGE and MPR; when regi_pageTO≠0 and to_cnt==regi_pageTO-1 on m_tslot_p → page_timeout_p, go IDLE.
- PAGE + rx_id_p → MPR; presp_cnt cleared; slot_cnt/rep_cnt/Atrain/k_nudge held.
- MPR: presp_cnt increments on m_tslot_p. mpr_done_p → page_succ_p, IDLE. mpr_fail_p or presp_cnt reaching PRESP_TO-1 on m_tslot_p → back to PAGE, train counters resume from held values.
- Priority in any cycle: page_abort_p > page_timeout > mpr_done_p > rx_id_p / mpr_fail_p / presp timeout > slot advance. rx_id_p together with a train-end m_tslot_p: state goes MPR, counters do not advance.
- page_start_p outside IDLE ignored. rx_id_p, mpr_done_p, mpr_fail_p outside their state ignored.
- k_nudge and Atrain held through MPR and IDLE (last value) until the next page_start_p.

## Timing
- Reset: state IDLE; all outputs 0 (page, mpr, Atrain, k_nudge, pageAB_2Npage_count, prm_clock_frozen, pulses).
- All outputs registered; state changes visible the cycle after the triggering pulse.
- page rises 1 cycle after page_start_p; prm_clock_frozen rises 1 cycle after rx_id_p and falls 1 cycle after exit pulse.
- Atrain/k_nudge change 1 cycle after the train-end m_tslot_p.
- page_succ_p / page_timeout_p high exactly 1 cycle, coincident with the state becoming IDLE.
- Abort mid-MPR: freeze drops next cycle, no success/timeout pulse.

## Structure
- Shared package (bt_pkg): state encoding (IDLE=0, PAGE=1, MPR=2), TRAIN_SLOTS, PRESP_TO, K_NUDGE_STEP=2.
- One sub-module: page_slot_cnt (slot_cnt + rep_cnt + half + nudge update, with hold input); FSM, timeout and pulses in the top.

## Test plan
- Npage=1, init A, TO=0: start, 64 m_tslot_p → Atrain toggles at slots 16/32/48/64, k_nudge 0→2 at slot 32 →4 at slot 64, count=2.
- Npage=0: same behaviour as Npage=1 (toggle every 16 slots).
- rx_id_p at slot 10, then 3 slots, mpr_done_p → mpr/prm_clock_frozen high 1 cycle after rx_id_p, page_succ_p one pulse, IDLE, k_nudge unchanged.
- rx_id_p at slot 5, no done for 8 slots → back to PAGE, next Atrain toggle at slot 16+8=24 of wall time (counters held).
- regi_pageTO=20 → page_timeout_p on 20th m_tslot_p, IDLE; rx_id_p same cycle → timeout wins.
- Abort during MPR, and rstz asserted mid-PAGE → all outputs 0 next cycle / immediately, no pulses.
